// File: rtl/n64_vinfo_ext.sv
// N64 video-info extractor: slot counter, pixel phase, 480i and PAL detection.
// Optional PAL line counting is enabled by defining N64_VINFO_PAL_DETECT_EN.
module n64_vinfo_ext #(
  parameter int                    LINE_CNT_W  = 10,
  parameter logic [LINE_CNT_W-1:0] PAL_LINE_TH = LINE_CNT_W'(288)
) (
  input  logic       nCLK,
  input  logic       nRST,
  input  logic       nDSYNC,
  input  logic [3:0] D_i,
  output logic [1:0] data_cnt_o,
  output logic       blurry_pixel_pos_o,
  output logic       n64_480i_o,
  output logic       vmode_o,
  output logic [3:0] sync_o
);

  logic [1:0] r_data_cnt;
  logic       r_blur;
  logic [3:0] r_sync;
  logic       r_480i;
  logic [1:0] r_conf;
  logic       r_f_prev;
  logic       r_first;

  logic w_sw;
  logic w_neg_h;
  logic w_neg_v;
  logic w_tog;
  logic w_agree;

  assign w_sw    = ~nDSYNC;
  assign w_neg_h = w_sw & r_sync[1] & ~D_i[1];
  assign w_neg_v = w_sw & r_sync[3] & ~D_i[3];
  assign w_tog   = D_i[1] ^ r_f_prev;
  // a frame agrees when it argues for the opposite of the current mode
  assign w_agree = w_tog ^ r_480i;

  always_ff @(negedge nCLK) begin
    if (!nRST) begin
      r_data_cnt <= 2'd0;
      r_blur     <= 1'b1;
      r_sync     <= 4'hF;
    end else if (w_sw) begin
      r_data_cnt <= 2'd1;
      r_sync     <= D_i;
      r_blur     <= w_neg_h ? 1'b1 : ~r_blur;
    end else begin
      r_data_cnt <= r_data_cnt + 2'd1;
    end
  end

  always_ff @(negedge nCLK) begin
    if (!nRST) begin
      r_480i   <= 1'b0;
      r_conf   <= 2'd0;
      r_f_prev <= 1'b1;
      r_first  <= 1'b1;
    end else if (w_neg_v) begin
      r_f_prev <= D_i[1];
      r_first  <= 1'b0;
      if (!r_first) begin
        if (!w_agree) begin
          r_conf <= 2'd0;
        end else if (r_conf == 2'd1) begin
          r_480i <= ~r_480i;
          r_conf <= 2'd0;
        end else begin
          r_conf <= r_conf + 2'd1;
        end
      end
    end
  end

`ifdef N64_VINFO_PAL_DETECT_EN
  logic [LINE_CNT_W-1:0] r_line_cnt;
  logic                  r_vmode;

  // vsync clears first so a coincident hsync edge is not counted
  always_ff @(negedge nCLK) begin
    if (!nRST) begin
      r_line_cnt <= '0;
      r_vmode    <= 1'b0;
    end else if (w_neg_v) begin
      r_line_cnt <= '0;
      if (!r_first)
        r_vmode <= (r_line_cnt >= PAL_LINE_TH);
    end else if (w_neg_h && (r_line_cnt != '1)) begin
      r_line_cnt <= r_line_cnt + 1'b1;
    end
  end

  assign vmode_o = r_vmode;
`else
  logic w_unused;
  assign w_unused = ^PAL_LINE_TH;
  assign vmode_o  = 1'b0;
`endif

  assign data_cnt_o         = r_data_cnt;
  assign blurry_pixel_pos_o = r_blur;
  assign n64_480i_o         = r_480i;
  assign sync_o             = r_sync;

endmodule

// File: doc/n64_vinfo_ext.md
# n64_vinfo_ext

Video-info extractor that sits directly upstream of the deblur estimator and the pixel demux. It parses the 4-bit sync nibble the N64 places on the data bus during each nDSYNC-low cycle. From it the block generates:
- the colour-slot counter,
- the blurry-pixel phase flag,
- 480i detection,
- PAL/NTSC detection.

All of these feed the packed deblur parameter vector.

## Interface
Parameters:
- LINE_CNT_W, 10, width of the per-frame line counter.
- PAL_LINE_TH, 10'd288, line-count threshold: a frame with this many lines or more is classified as PAL.

Ports:
- nCLK  input  1  N64 pixel-bus clock; all state updates on negedge nCLK.
- nRST  input  1  reset nRST, synchronous, active-low.
- nDSYNC  input  1  low marks the sync-word cycle of each 4-cycle pixel group.
- D_i  input  4  data bus bits [3:0]; during the sync word these are {nVSYNC, nCLAMP, nHSYNC, nCSYNC}.
- data_cnt_o  output  2  colour slot: 0 = sync word, 1 = R, 2 = G, 3 = B.
- blurry_pixel_pos_o  output  1  pixel phase flag; toggles once per pixel group.
- n64_480i_o  output  1  1 = interlaced (480i/576i) content detected.
- vmode_o  output  1  1 = PAL, 0 = NTSC.
- sync_o  output  4  last captured sync nibble, same bit order as D_i.

## Operation
- **data_cnt_o**: a sync-word cycle (nDSYNC low) loads 2'b01 on the next negedge; every other cycle increments it modulo 4. A stray nDSYNC low mid-group re-aligns the counter immediately.
- **Sync capture**: on each sync word, sync_o <= D_i.
- **Edge detection**: edges are evaluated only in sync-word cycles, by comparing sync_o with the current D_i.
  - negedge_nHSYNC = sync_o[1] & !D_i[1].
  - negedge_nVSYNC = sync_o[3] & !D_i[3].
- **blurry_pixel_pos_o**: toggles on every sync word.
  - On a sync word carrying negedge_nHSYNC it is forced to 1 instead of toggling.
  - This line-start forcing takes priority over the toggle.
- **Line counter** (LINE_CNT_W bits):
  - Increments on negedge_nHSYNC and saturates at all-ones.
  - Cleared to 0 on negedge_nVSYNC.
  - If negedge_nHSYNC and negedge_nVSYNC occur in the same sync word, the counter is cleared and that line is not counted.
- **Interlace detection**:
  - At negedge_nVSYNC, sample field bit f = D_i[1] (nHSYNC level at the vsync edge) and compare it with f_prev.
  - A 2-bit confirm counter counts consecutive frames that agree with the opposite of the current n64_480i_o:
    - a toggle (f != f_prev) counts towards setting;
    - a non-toggle counts towards clearing.
  - When the count reaches 2, n64_480i_o flips and the confirm counter clears. A disagreeing frame also clears the confirm counter.
  - f_prev <= f at every vsync edge.
- **PAL detection**: see Configuration.
- The first vsync edge after reset only primes f_prev and the line counter. It has no effect on n64_480i_o or vmode_o.

## Timing
- Reset values: data_cnt_o 0, blurry_pixel_pos_o 1, n64_480i_o 0, vmode_o 0, sync_o 4'hF.
- Internal reset values: line counter 0, confirm counter 0, f_prev 1, first-frame flag set.
- Reset is sampled on negedge nCLK. Asserting it mid-frame discards all partial counts. The resulting outputs are exactly the reset values on the following cycle.
- Latency:
  - data_cnt_o and sync_o: 1 nCLK cycle after the sync word.
  - blurry_pixel_pos_o changes on the same negedge that loads data_cnt_o = 1. Downstream therefore sees the new phase during R/G/B of that group.
- Mode flags (n64_480i_o, vmode_o) change only on a negedge_nVSYNC sync word, 1 cycle later. They are stable for the whole frame.
- Line counter saturation: if no vsync arrives, vmode_o holds its last value. A saturated count (all-ones) at a vsync edge counts as ≥ PAL_LINE_TH.

## Configuration
- Macro N64_VINFO_PAL_DETECT_EN.
- **Defined**: at each non-first negedge_nVSYNC, vmode_o <= (line count ≥ PAL_LINE_TH).
- **Undefined**:
  - vmode_o is tied to 0.
  - The line counter and its comparator are not synthesised.
  - PAL_LINE_TH is ignored.
  - All other behaviour is identical.

## Test plan
- Reset with nDSYNC low, then run 4-cycle groups (nDSYNC low once every 4 cycles) -> data_cnt_o sequence 1,2,3,0 repeating. blurry_pixel_pos_o is 1 after reset and alternates 0,1,0,… on successive groups.
- Insert negedge_nHSYNC into a group whose toggle would give 0 -> blurry_pixel_pos_o = 1 for that group.
- Feed 240p NTSC frames (263 lines, vsync edge with nHSYNC high every frame) -> n64_480i_o = 0 and vmode_o = 0 after the 2nd frame. Then 313-line frames (macro defined) -> vmode_o = 1 one cycle after the 2nd vsync edge.
- Alternate the vsync-edge nHSYNC level 1,0,1,0 -> n64_480i_o rises one cycle after the 3rd vsync edge (first edge primes f_prev, then two toggles). Return to constant level -> n64_480i_o falls after 2 non-toggling frames.
- Toggle, non-toggle, toggle pattern -> n64_480i_o stays 0 (confirm counter cleared by the disagreeing frame).
- Assert nRST mid-frame after 150 lines -> all outputs at reset values next cycle. The next vsync edge is treated as the first, and vmode_o stays 0.
